reorder_buffer: RTL and testbench

//  Circular in-order commit queue of the Tomasulo core. Allocates a tag per decoded instruction,

---
 rtl/reorder_buffer_if.sv | 60 ++++++
 rtl/reorder_buffer.sv | 145 ++++++++++++++
 tb/tb_reorder_buffer.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/reorder_buffer_if.sv
// Decoder, CDB and commit/rollback bundle of the reorder buffer.
// The master side is the rest of the core; the slave side is the ROB itself.
interface reorder_buffer_if #(
  parameter int TAG_W  = 5,
  parameter int WORD_W = 32,
  parameter int REG_W  = 5
);
  logic              dec_issue_in;
  logic [WORD_W-1:0] dec_pc_in;
  logic [REG_W-1:0]  dec_rd_in;
  logic              dec_occupy_rd_in;
  logic              dec_is_branch_in;
  logic              dec_pred_taken_in;
  logic [TAG_W-1:0]  dec_Qj_in;
  logic [TAG_W-1:0]  dec_Qk_in;

  logic [TAG_W-1:0]  rob_next_tag_out;
  logic              rob_full_out;
  logic              rob_Qj_ready_out;
  logic              rob_Qk_ready_out;
  logic [WORD_W-1:0] rob_Qj_value_out;
  logic [WORD_W-1:0] rob_Qk_value_out;

  logic              cdb_valid_in;
  logic [TAG_W-1:0]  cdb_tag_in;
  logic [WORD_W-1:0] cdb_value_in;
  logic              cdb_jump_in;
  logic [WORD_W-1:0] cdb_target_in;

  logic              rob_commit_signal_out;
  logic              rob_commit_rf_signal_out;
  logic [WORD_W-1:0] rob_commit_pc_out;
  logic [TAG_W-1:0]  rob_commit_tag_out;
  logic [WORD_W-1:0] rob_commit_data_out;
  logic [REG_W-1:0]  rob_commit_target_out;
  logic              rob_rollback_out;
  logic [WORD_W-1:0] rob_rollback_pc_out;

  modport master (
    output dec_issue_in, dec_pc_in, dec_rd_in, dec_occupy_rd_in, dec_is_branch_in,
           dec_pred_taken_in, dec_Qj_in, dec_Qk_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in, cdb_jump_in, cdb_target_in,
    input  rob_next_tag_out, rob_full_out, rob_Qj_ready_out, rob_Qk_ready_out,
           rob_Qj_value_out, rob_Qk_value_out,
           rob_commit_signal_out, rob_commit_rf_signal_out, rob_commit_pc_out,
           rob_commit_tag_out, rob_commit_data_out, rob_commit_target_out,
           rob_rollback_out, rob_rollback_pc_out
  );

  modport slave (
    input  dec_issue_in, dec_pc_in, dec_rd_in, dec_occupy_rd_in, dec_is_branch_in,
           dec_pred_taken_in, dec_Qj_in, dec_Qk_in,
           cdb_valid_in, cdb_tag_in, cdb_value_in, cdb_jump_in, cdb_target_in,
    output rob_next_tag_out, rob_full_out, rob_Qj_ready_out, rob_Qk_ready_out,
           rob_Qj_value_out, rob_Qk_value_out,
           rob_commit_signal_out, rob_commit_rf_signal_out, rob_commit_pc_out,
           rob_commit_tag_out, rob_commit_data_out, rob_commit_target_out,
           rob_rollback_out, rob_rollback_pc_out
  );
endinterface

// File: rtl/reorder_buffer.sv
// Circular in-order commit queue: allocates tags, captures CDB results, retires the head
// in program order and flushes everything when a retiring branch was mispredicted.
module reorder_buffer #(
  parameter int ROB_DEPTH = 16,
  parameter int TAG_W     = 5,
  parameter int WORD_W    = 32,
  parameter int REG_W     = 5
) (
  input logic             clk,
  input logic             rst,
  reorder_buffer_if.slave bus
);
  localparam int IDX_W = (ROB_DEPTH > 1) ? $clog2(ROB_DEPTH) : 1;
  localparam int CNT_W = $clog2(ROB_DEPTH + 1);

  logic [IDX_W-1:0]  head;
  logic [IDX_W-1:0]  tail;
  logic [CNT_W-1:0]  count;

  logic              busy      [ROB_DEPTH];
  logic              done      [ROB_DEPTH];
  logic [WORD_W-1:0] pc_q      [ROB_DEPTH];
  logic [REG_W-1:0]  rd_q      [ROB_DEPTH];
  logic              occupy_q  [ROB_DEPTH];
  logic              branch_q  [ROB_DEPTH];
  logic              pred_q    [ROB_DEPTH];
  logic [WORD_W-1:0] value_q   [ROB_DEPTH];
  logic              jump_q    [ROB_DEPTH];
  logic [WORD_W-1:0] target_q  [ROB_DEPTH];

  logic              full;
  logic              do_issue;
  logic              do_commit;
  logic              mispredict;
  logic              wb_hit;
  logic [IDX_W-1:0]  wb_idx;

  // Tag t lives in slot t-1; tag 0 is the null tag and never names a slot.
  function automatic logic tag_ok(input logic [TAG_W-1:0] t);
    return (t != '0) && (t <= TAG_W'(ROB_DEPTH));
  endfunction

  function automatic logic [IDX_W-1:0] tag_idx(input logic [TAG_W-1:0] t);
    return IDX_W'(t - TAG_W'(1));
  endfunction

  function automatic logic [IDX_W-1:0] idx_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(ROB_DEPTH - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // Operand lookup; a result on the CDB this cycle takes priority over the stored copy.
  function automatic logic [WORD_W:0] lookup(input logic [TAG_W-1:0] t);
    logic [WORD_W:0] r;
    r = '0;
    if (t == '0) begin
      r = {1'b1, {WORD_W{1'b0}}};
    end else if (bus.cdb_valid_in && (bus.cdb_tag_in == t)) begin
      r = {1'b1, bus.cdb_value_in};
    end else if (tag_ok(t) && busy[tag_idx(t)] && done[tag_idx(t)]) begin
      r = {1'b1, value_q[tag_idx(t)]};
    end
    return r;
  endfunction

  always_comb begin
    full       = (count == CNT_W'(ROB_DEPTH));
    do_issue   = bus.dec_issue_in && !full;
    do_commit  = (count != '0) && busy[head] && done[head];
    mispredict = do_commit && branch_q[head] && (jump_q[head] != pred_q[head]);
    wb_idx     = tag_idx(bus.cdb_tag_in);
    wb_hit     = bus.cdb_valid_in && tag_ok(bus.cdb_tag_in) && busy[wb_idx];
  end

  always_comb begin
    bus.rob_next_tag_out = TAG_W'(tail) + TAG_W'(1);
    bus.rob_full_out     = full;
    {bus.rob_Qj_ready_out, bus.rob_Qj_value_out} = lookup(bus.dec_Qj_in);
    {bus.rob_Qk_ready_out, bus.rob_Qk_value_out} = lookup(bus.dec_Qk_in);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < ROB_DEPTH; i++) begin
        busy[i] <= 1'b0;
        done[i] <= 1'b0;
      end
      bus.rob_commit_signal_out    <= 1'b0;
      bus.rob_commit_rf_signal_out <= 1'b0;
      bus.rob_commit_pc_out        <= '0;
      bus.rob_commit_tag_out       <= '0;
      bus.rob_commit_data_out      <= '0;
      bus.rob_commit_target_out    <= '0;
      bus.rob_rollback_out         <= 1'b0;
      bus.rob_rollback_pc_out      <= '0;
    end else begin
      bus.rob_commit_signal_out    <= do_commit;
      bus.rob_commit_rf_signal_out <= do_commit && occupy_q[head] && !branch_q[head];
      bus.rob_commit_pc_out        <= do_commit ? pc_q[head] : '0;
      bus.rob_commit_tag_out       <= do_commit ? TAG_W'(head) + TAG_W'(1) : '0;
      bus.rob_commit_data_out      <= do_commit ? value_q[head] : '0;
      bus.rob_commit_target_out    <= do_commit ? rd_q[head] : '0;
      bus.rob_rollback_out         <= mispredict;
      bus.rob_rollback_pc_out      <= !mispredict ? '0 :
                                      jump_q[head] ? target_q[head] :
                                      pc_q[head] + WORD_W'(4);

      if (mispredict) begin
        // Everything younger than the branch is wrong-path; same-edge issue/CDB are dropped.
        head  <= '0;
        tail  <= '0;
        count <= '0;
        for (int i = 0; i < ROB_DEPTH; i++) begin
          busy[i] <= 1'b0;
          done[i] <= 1'b0;
        end
      end else begin
        if (wb_hit) begin
          value_q[wb_idx]  <= bus.cdb_value_in;
          jump_q[wb_idx]   <= bus.cdb_jump_in;
          target_q[wb_idx] <= bus.cdb_target_in;
          done[wb_idx]     <= 1'b1;
        end
        if (do_commit) begin
          busy[head] <= 1'b0;
          done[head] <= 1'b0;
          head       <= idx_inc(head);
        end
        if (do_issue) begin
          busy[tail]     <= 1'b1;
          done[tail]     <= 1'b0;
          pc_q[tail]     <= bus.dec_pc_in;
          rd_q[tail]     <= bus.dec_rd_in;
          occupy_q[tail] <= bus.dec_occupy_rd_in;
          branch_q[tail] <= bus.dec_is_branch_in;
          pred_q[tail]   <= bus.dec_pred_taken_in;
          tail           <= idx_inc(tail);
        end
        count <= count + CNT_W'(do_issue) - CNT_W'(do_commit);
      end
    end
  end
endmodule

// File: tb/tb_reorder_buffer.sv
// Directed bench for reorder_buffer: a queue-based model of the ROB checked every cycle,
// plus literal expectations at the key points of each scenario.
module tb_reorder_buffer;
  localparam int DEPTH = 16;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  reorder_buffer_if #(.TAG_W(5), .WORD_W(32), .REG_W(5)) bus();

  reorder_buffer #(.ROB_DEPTH(DEPTH), .TAG_W(5), .WORD_W(32), .REG_W(5)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  bit cmp_en  = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
  endtask

  // Model: the ROB is just an ordered list of in-flight instructions.
  typedef struct {
    int          tag;
    logic [31:0] pc;
    logic [4:0]  rd;
    bit          occ, br, pred, rdy, jump;
    logic [31:0] val, tgt;
  } ent_t;

  ent_t        q[$];
  int          m_next = 1;
  bit          e_commit, e_rf, e_rb;
  logic [31:0] e_pc, e_data, e_rbpc;
  int          e_tag;
  logic [4:0]  e_rd;

  always @(posedge clk) begin : model
    bit   com, full_pre, mis;
    ent_t h, n;
    if (!rst) begin
      q.delete();
      m_next = 1;
      e_commit = 0; e_rf = 0; e_rb = 0;
      e_pc = 0; e_data = 0; e_rbpc = 0; e_tag = 0; e_rd = 0;
    end else begin
      full_pre = (q.size() == DEPTH);
      com      = (q.size() > 0) && q[0].rdy;
      mis      = 0;
      e_commit = com; e_rf = 0; e_rb = 0;
      e_pc = 0; e_data = 0; e_rbpc = 0; e_tag = 0; e_rd = 0;
      if (com) begin
        h      = q[0];
        e_rf   = h.occ && !h.br;
        e_pc   = h.pc;
        e_tag  = h.tag;
        e_data = h.val;
        e_rd   = h.rd;
        mis    = h.br && (h.jump != h.pred);
        e_rb   = mis;
        if (mis) e_rbpc = h.jump ? h.tgt : h.pc + 32'd4;
      end
      if (mis) begin
        q.delete();
        m_next = 1;
      end else begin
        if (bus.cdb_valid_in)
          foreach (q[i])
            if (q[i].tag == int'(bus.cdb_tag_in)) begin
              q[i].rdy  = 1;
              q[i].val  = bus.cdb_value_in;
              q[i].jump = bus.cdb_jump_in;
              q[i].tgt  = bus.cdb_target_in;
            end
        if (com) void'(q.pop_front());
        if (bus.dec_issue_in && !full_pre) begin
          n.tag = m_next; n.pc = bus.dec_pc_in; n.rd = bus.dec_rd_in;
          n.occ = bus.dec_occupy_rd_in; n.br = bus.dec_is_branch_in;
          n.pred = bus.dec_pred_taken_in; n.rdy = 0; n.jump = 0; n.val = 0; n.tgt = 0;
          q.push_back(n);
          m_next = (m_next == DEPTH) ? 1 : m_next + 1;
        end
      end
    end
  end

  function automatic void model_query(input logic [4:0] t, output bit r, output logic [31:0] v);
    r = 0;
    v = 0;
    if (t == 0) r = 1;
    else if (bus.cdb_valid_in && bus.cdb_tag_in == t) begin
      r = 1;
      v = bus.cdb_value_in;
    end else
      foreach (q[i])
        if (q[i].tag == int'(t) && q[i].rdy) begin
          r = 1;
          v = q[i].val;
        end
  endfunction

  always @(negedge clk) begin : compare
    bit          r;
    logic [31:0] v;
    if (cmp_en) begin
      check("next_tag", 32'(bus.rob_next_tag_out), m_next);
      check("full", 32'(bus.rob_full_out), 32'(q.size() == DEPTH));
      check("commit", 32'(bus.rob_commit_signal_out), 32'(e_commit));
      check("commit_rf", 32'(bus.rob_commit_rf_signal_out), 32'(e_rf));
      check("commit_pc", bus.rob_commit_pc_out, e_pc);
      check("commit_tag", 32'(bus.rob_commit_tag_out), e_tag);
      check("commit_data", bus.rob_commit_data_out, e_data);
      check("commit_rd", 32'(bus.rob_commit_target_out), 32'(e_rd));
      check("rollback", 32'(bus.rob_rollback_out), 32'(e_rb));
      check("rollback_pc", bus.rob_rollback_pc_out, e_rbpc);
      model_query(bus.dec_Qj_in, r, v);
      check("qj_ready", 32'(bus.rob_Qj_ready_out), 32'(r));
      check("qj_value", bus.rob_Qj_value_out, v);
      model_query(bus.dec_Qk_in, r, v);
      check("qk_ready", 32'(bus.rob_Qk_ready_out), 32'(r));
      check("qk_value", bus.rob_Qk_value_out, v);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    bus.dec_issue_in = 0; bus.dec_pc_in = 0; bus.dec_rd_in = 0; bus.dec_occupy_rd_in = 0;
    bus.dec_is_branch_in = 0; bus.dec_pred_taken_in = 0; bus.dec_Qj_in = 0; bus.dec_Qk_in = 0;
    bus.cdb_valid_in = 0; bus.cdb_tag_in = 0; bus.cdb_value_in = 0;
    bus.cdb_jump_in = 0; bus.cdb_target_in = 0;
  endtask

  task automatic issue(input logic [31:0] pc, input logic [4:0] rd, input bit occ,
                       input bit br, input bit pred);
    bus.dec_issue_in = 1; bus.dec_pc_in = pc; bus.dec_rd_in = rd;
    bus.dec_occupy_rd_in = occ; bus.dec_is_branch_in = br; bus.dec_pred_taken_in = pred;
    tick();
    bus.dec_issue_in = 0;
  endtask

  task automatic cdb(input logic [4:0] tag, input logic [31:0] val, input bit jump,
                     input logic [31:0] tgt);
    bus.cdb_valid_in = 1; bus.cdb_tag_in = tag; bus.cdb_value_in = val;
    bus.cdb_jump_in = jump; bus.cdb_target_in = tgt;
    tick();
    bus.cdb_valid_in = 0;
  endtask

  task automatic do_reset();
    rst = 0;
    tick();
    rst = 1;
  endtask

  initial begin
    idle();
    rst = 0;
    tick();
    tick();
    cmp_en = 1;
    check("t1_commit", 32'(bus.rob_commit_signal_out), 0);
    check("t1_rollback", 32'(bus.rob_rollback_out), 0);
    check("t1_next_tag", 32'(bus.rob_next_tag_out), 1);
    check("t1_full", 32'(bus.rob_full_out), 0);
    check("t1_data", bus.rob_commit_data_out, 0);
    rst = 1;

    // in-order commit of out-of-order writebacks
    issue(32'h0, 5'd1, 1, 0, 0);
    issue(32'h4, 5'd2, 1, 0, 0);
    issue(32'h8, 5'd3, 1, 0, 0);
    check("t2_next_tag", 32'(bus.rob_next_tag_out), 4);
    cdb(5'd2, 32'h22, 0, 0);
    cdb(5'd1, 32'h11, 0, 0);
    check("t2_no_early_commit", 32'(bus.rob_commit_signal_out), 0);
    cdb(5'd3, 32'h33, 0, 0);
    check("t2_c1_sig", 32'(bus.rob_commit_signal_out), 1);
    check("t2_c1_tag", 32'(bus.rob_commit_tag_out), 1);
    check("t2_c1_data", bus.rob_commit_data_out, 32'h11);
    check("t2_c1_rd", 32'(bus.rob_commit_target_out), 1);
    check("t2_c1_rf", 32'(bus.rob_commit_rf_signal_out), 1);
    tick();
    check("t2_c2_tag", 32'(bus.rob_commit_tag_out), 2);
    check("t2_c2_data", bus.rob_commit_data_out, 32'h22);
    check("t2_c2_pc", bus.rob_commit_pc_out, 32'h4);
    tick();
    check("t2_c3_tag", 32'(bus.rob_commit_tag_out), 3);
    check("t2_c3_data", bus.rob_commit_data_out, 32'h33);
    check("t2_c3_rd", 32'(bus.rob_commit_target_out), 3);
    tick();
    check("t2_idle_commit", 32'(bus.rob_commit_signal_out), 0);
    check("t2_idle_data", bus.rob_commit_data_out, 0);

    // full, dropped issue, wrap of the tag sequence
    do_reset();
    for (int i = 0; i < DEPTH; i++) issue(32'h1000 + 32'(4 * i), 5'(i), 1, 0, 0);
    check("t3_full", 32'(bus.rob_full_out), 1);
    check("t3_next_tag_wrap", 32'(bus.rob_next_tag_out), 1);
    issue(32'hDEAD, 5'd31, 1, 0, 0);
    check("t3_full_after_drop", 32'(bus.rob_full_out), 1);
    cdb(5'd1, 32'h77, 0, 0);
    tick();
    check("t3_commit_tag", 32'(bus.rob_commit_tag_out), 1);
    check("t3_commit_data", bus.rob_commit_data_out, 32'h77);
    check("t3_not_full", 32'(bus.rob_full_out), 0);
    issue(32'h2000, 5'd9, 1, 0, 0);
    check("t3_full_again", 32'(bus.rob_full_out), 1);
    check("t3_next_tag_2", 32'(bus.rob_next_tag_out), 2);

    // taken branch predicted not-taken
    do_reset();
    issue(32'h80, 5'd0, 0, 1, 0);
    issue(32'h84, 5'd5, 1, 0, 0);
    cdb(5'd1, 32'h0, 1, 32'h100);
    cdb(5'd2, 32'h55, 0, 0);
    check("t4_commit", 32'(bus.rob_commit_signal_out), 1);
    check("t4_rollback", 32'(bus.rob_rollback_out), 1);
    check("t4_rb_pc", bus.rob_rollback_pc_out, 32'h100);
    check("t4_rf", 32'(bus.rob_commit_rf_signal_out), 0);
    check("t4_next_tag", 32'(bus.rob_next_tag_out), 1);
    tick();
    tick();
    check("t4_tag2_dropped", 32'(bus.rob_commit_signal_out), 0);
    // not-taken branch predicted taken
    issue(32'h200, 5'd0, 0, 1, 1);
    cdb(5'd1, 32'h0, 0, 32'h300);
    tick();
    check("t4_rb2", 32'(bus.rob_rollback_out), 1);
    check("t4_rb2_pc", bus.rob_rollback_pc_out, 32'h204);
    // correctly predicted branch retires quietly
    issue(32'h300, 5'd0, 0, 1, 1);
    cdb(5'd1, 32'h0, 1, 32'h400);
    tick();
    check("t4_ok_commit", 32'(bus.rob_commit_signal_out), 1);
    check("t4_ok_no_rb", 32'(bus.rob_rollback_out), 0);
    check("t4_ok_next_tag", 32'(bus.rob_next_tag_out), 2);

    // operand queries with CDB bypass
    do_reset();
    issue(32'h10, 5'd1, 1, 0, 0);
    issue(32'h14, 5'd2, 1, 0, 0);
    issue(32'h18, 5'd3, 1, 0, 0);
    bus.dec_Qj_in = 5'd3; bus.dec_Qk_in = 5'd0;
    bus.cdb_valid_in = 1; bus.cdb_tag_in = 5'd3; bus.cdb_value_in = 32'hAB;
    #1;
    check("t5_qj_bypass_ready", 32'(bus.rob_Qj_ready_out), 1);
    check("t5_qj_bypass_value", bus.rob_Qj_value_out, 32'hAB);
    check("t5_qk_null_ready", 32'(bus.rob_Qk_ready_out), 1);
    check("t5_qk_null_value", bus.rob_Qk_value_out, 0);
    tick();
    bus.cdb_valid_in = 0;
    #1;
    check("t5_qj_stored", bus.rob_Qj_value_out, 32'hAB);
    bus.dec_Qj_in = 5'd2;
    #1;
    check("t5_qj_pending_ready", 32'(bus.rob_Qj_ready_out), 0);
    check("t5_qj_pending_value", bus.rob_Qj_value_out, 0);
    tick();
    idle();

    // reset mid-flight overrides a ready head
    do_reset();
    for (int i = 0; i < 5; i++) issue(32'h40 + 32'(4 * i), 5'(i + 1), 1, 0, 0);
    cdb(5'd1, 32'h99, 0, 0);
    rst = 0;
    bus.dec_issue_in = 1;
    tick();
    check("t6_no_commit", 32'(bus.rob_commit_signal_out), 0);
    check("t6_next_tag", 32'(bus.rob_next_tag_out), 1);
    check("t6_full", 32'(bus.rob_full_out), 0);
    rst = 1;
    bus.dec_issue_in = 0;
    tick();
    check("t6_still_empty", 32'(bus.rob_commit_signal_out), 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
